axis_mem_initiator: RTL
=======================

// Module: axis_mem_initiator
// PURPOSE
//   Stream initiator and read-back checker for the AXI-Stream memory path.
//   Transmits a programmable burst of pattern words on its master port into the memory's slave port.
//   Accepts the words streamed back from the memory's master port and checks them against the same pattern.
//   Reports beat and error counts for self-test of the memory controller and memory pair.
// PARAMETERS
//   DATA_WIDTH      32    stream data width in bits (multiple of 8)
//   LEN_WIDTH       12    width of burst_len; max burst 2^LEN_WIDTH-1 beats
//   TIMEOUT_CYCLES  1024  watchdog limit in WAIT_RX (only used with INIT_TIMEOUT_EN)
// PORTS
//   m00_axis_aclk     in   1             single clock for both stream interfaces and control
//   m00_axis_aresetn  in   1             async active-low reset
//   start             in   1             1-cycle request to begin a burst
//   burst_len         in   LEN_WIDTH     beats per burst, sampled on an accepted start
//   seed              in   DATA_WIDTH    pattern base, sampled on an accepted start
//   busy              out  1             high from accepted start until done
//   done              out  1             1-cycle pulse at burst completion
//   timeout           out  1             sticky; last burst ended by the watchdog
//   rx_count          out  LEN_WIDTH     beats accepted on s00 for the current/last burst
//   err_count         out  LEN_WIDTH+1   mismatches for the current/last burst (saturating)
//   m00_axis_tdata    out  DATA_WIDTH    tx data
//   m00_axis_tstrb    out  DATA_WIDTH/8  tx byte strobes
//   m00_axis_tvalid   out  1             tx valid
//   m00_axis_tlast    out  1             tx last beat
//   m00_axis_tready   in   1             tx ready
//   s00_axis_tdata    in   DATA_WIDTH    rx data
//   s00_axis_tstrb    in   DATA_WIDTH/8  rx strobes (ignored)
//   s00_axis_tvalid   in   1             rx valid
//   s00_axis_tlast    in   1             rx last beat
//   s00_axis_tready   out  1             rx ready
// BEHAVIOUR
//   Reset: every output is 0; FSM goes to IDLE. All outputs are registered.
//   FSM states: IDLE -> SEND -> WAIT_RX -> DONE -> IDLE.
//   IDLE:
//     - start=1 with burst_len!=0 latches len/seed, clears tx_idx, rx_idx, rx_count, err_count and timeout.
//     - In the same transition, busy=1 and the FSM moves to SEND.
//     - start with burst_len==0 is ignored. start outside IDLE is ignored.
//   SEND:
//     - m00_axis_tvalid=1 from the cycle after the accepted start.
//     - tdata = seed+tx_idx (mod 2^DATA_WIDTH); tstrb = all ones.
//     - tlast = (tx_idx==len-1).
//     - tdata, tstrb and tlast hold stable while tvalid&&!tready.
//     - tx_idx increments on each tvalid&&tready.
//     - The handshake of the last beat clears tvalid on the next cycle and moves the FSM to WAIT_RX.
//   RX (active in both SEND and WAIT_RX):
//     - s00_axis_tready=1; it is 0 in IDLE and DONE.
//     - Each s00 handshake compares tdata with seed+rx_idx.
//     - Mismatch -> err_count+1. An extra +1 if tlast != (rx_idx==len-1).
//     - err_count saturates at all ones.
//     - rx_idx and rx_count increment per handshake.
//   WAIT_RX:
//     - Accepting the beat with rx_idx==len-1 goes to DONE.
//     - This applies even if the beat arrives while still in SEND; in that case DONE follows once the tx side has finished.
//   DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. Counts hold until the next start.
//   Simultaneous tx and rx handshakes in one cycle are both processed.
//   Async reset mid-burst: tvalid and s00 tready drop immediately; counters clear.
// CONFIGURATION
//   INIT_TIMEOUT_EN defined:
//     - A watchdog counts cycles in WAIT_RX and clears on every rx handshake.
//     - At TIMEOUT_CYCLES the FSM goes to DONE and sets timeout=1.
//   INIT_TIMEOUT_EN undefined:
//     - No watchdog; WAIT_RX waits indefinitely.
//     - timeout is tied to 0.
// TESTING
//   T1: seed=32'h100, burst_len=4, loopback, tready always 1.
//       -> tx beats 100,101,102,103, tlast on the 4th; done 1 cycle after the 4th rx beat; rx_count=4, err_count=0.
//   T2: burst_len=3, tx tready toggling 1-0-1-0.
//       -> tdata/tlast stable during stalls; exactly 3 tx handshakes; err_count=0.
//   T3: seed=32'hFFFF_FFFE, len=4.
//       -> tx data FFFFFFFE, FFFFFFFF, 0, 1; loopback err_count=0.
//   T4: len=4, corrupt the 2nd rx word and assert tlast on the 3rd rx beat.
//       -> err_count=3 (mismatch, early tlast, missing tlast); rx_count=4.
//   T5: start while busy; start with burst_len=0.
//       -> both ignored; busy unchanged.
//   T6: with INIT_TIMEOUT_EN, no rx beats.
//       -> done and timeout=1 after TIMEOUT_CYCLES in WAIT_RX.
//   T7: reset asserted mid-SEND.
//       -> tvalid=0 immediately; FSM in IDLE.

Source files
------------

// File: rtl/axis_mem_initiator.sv
// AXI-Stream burst initiator and read-back checker for memory self-test.
// Optional watchdog in WAIT_RX enabled by defining INIT_TIMEOUT_EN.
module axis_mem_initiator #(
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 12,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    burst_len,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [LEN_WIDTH-1:0]    rx_count,
    output logic [LEN_WIDTH:0]      err_count,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
    input  logic                    s00_axis_tvalid,
    input  logic                    s00_axis_tlast,
    output logic                    s00_axis_tready
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, DONE} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   tx_idx;
    logic [LEN_WIDTH-1:0]   tx_nxt;
    logic [DATA_WIDTH-1:0]  seed_q;
    logic                   rx_seen;
    logic                   tx_hs, rx_hs, rx_is_last, rx_last_hs;
    logic                   start_acc, wd_fire;
    logic                   mism, lerr;
    logic [LEN_WIDTH+1:0]   err_sum;
    logic                   unused_tstrb;

    assign unused_tstrb = ^s00_axis_tstrb;
    assign tx_hs      = m00_axis_tvalid && m00_axis_tready;
    assign rx_hs      = s00_axis_tvalid && s00_axis_tready;
    assign tx_nxt     = tx_idx + 1'b1;
    assign rx_is_last = (rx_count == len_q - 1'b1);
    assign rx_last_hs = rx_hs && rx_is_last;
    assign start_acc  = (state == IDLE) && start && (burst_len != '0);
    assign mism       = (s00_axis_tdata != (seed_q + DATA_WIDTH'(rx_count)));
    assign lerr       = (s00_axis_tlast != rx_is_last);
    assign err_sum    = {1'b0, err_count} + (LEN_WIDTH+2)'(mism) + (LEN_WIDTH+2)'(lerr);

`ifdef INIT_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd;

    assign wd_fire = (state == WAIT_RX) && !rx_hs && (wd == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (start_acc) begin
            wd      <= '0;
            timeout <= 1'b0;
        end else if (state == WAIT_RX) begin
            if (rx_hs)
                wd <= '0;
            else if (wd_fire)
                timeout <= 1'b1;
            else
                wd <= wd + 1'b1;
        end else begin
            wd <= '0;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state           <= IDLE;
            len_q           <= '0;
            seed_q          <= '0;
            tx_idx          <= '0;
            rx_seen         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            rx_count        <= '0;
            err_count       <= '0;
            m00_axis_tdata  <= '0;
            m00_axis_tstrb  <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            s00_axis_tready <= 1'b0;
        end else begin
            done <= 1'b0;
            // rx checking runs independently of the tx side while tready is up
            if (rx_hs) begin
                rx_count  <= rx_count + 1'b1;
                err_count <= err_sum[LEN_WIDTH+1] ? '1 : err_sum[LEN_WIDTH:0];
            end
            case (state)
                IDLE: begin
                    if (start_acc) begin
                        len_q           <= burst_len;
                        seed_q          <= seed;
                        tx_idx          <= '0;
                        rx_count        <= '0;
                        err_count       <= '0;
                        rx_seen         <= 1'b0;
                        busy            <= 1'b1;
                        m00_axis_tvalid <= 1'b1;
                        m00_axis_tdata  <= seed;
                        m00_axis_tstrb  <= '1;
                        m00_axis_tlast  <= (burst_len == LEN_WIDTH'(1));
                        s00_axis_tready <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (rx_last_hs)
                        rx_seen <= 1'b1;
                    if (tx_hs) begin
                        tx_idx <= tx_nxt;
                        if (m00_axis_tlast) begin
                            m00_axis_tvalid <= 1'b0;
                            // the final rx beat may already have come back during SEND
                            if (rx_seen || rx_last_hs) begin
                                done            <= 1'b1;
                                busy            <= 1'b0;
                                s00_axis_tready <= 1'b0;
                                state           <= DONE;
                            end else begin
                                state <= WAIT_RX;
                            end
                        end else begin
                            m00_axis_tdata <= seed_q + DATA_WIDTH'(tx_nxt);
                            m00_axis_tlast <= (tx_nxt == len_q - 1'b1);
                        end
                    end
                end
                WAIT_RX: begin
                    if (rx_last_hs || wd_fire) begin
                        done            <= 1'b1;
                        busy            <= 1'b0;
                        s00_axis_tready <= 1'b0;
                        state           <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
